// File: rtl/ncsp_ddsm_pkg.sv
// Shared types and constants for the NCSP MASH delta-sigma configuration sequencer.
// The LFSR helpers are consumed only when NCSP_SEED_LFSR_EN is defined.
package ncsp_ddsm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RST  = 2'd1,
    ST_REL  = 2'd2,
    ST_RUN  = 2'd3
  } state_e;

  localparam int SEED_W     = 12;
  localparam int SUM_SEL_W  = 8;
  localparam int COUT_SEL_W = 9;

  // x^12 + x^6 + x^4 + x + 1, taken from state bits 11, 5, 3 and 0.
  localparam int                LFSR_W     = 12;
  localparam logic [LFSR_W-1:0] LFSR_TAPS  = 12'h829;
  localparam logic [LFSR_W-1:0] LFSR_RESET = 12'hACE;

  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
    return {s[LFSR_W-2:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/ncsp_ddsm_ctrl_lfsr.sv
// Fibonacci seed generator for the modulator; steps once per i_advance pulse.
// Only instantiated when NCSP_SEED_LFSR_EN is defined.
module ncsp_seed_lfsr
  import ncsp_ddsm_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_advance,
  output logic [LFSR_W-1:0] o_value
);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_value <= LFSR_RESET;
    end else if (i_advance) begin
      o_value <= lfsr_next(o_value);
    end
  end

endmodule

// File: rtl/ncsp_ddsm_ctrl.sv
// Configuration and staggered-reset sequencer for the NCSP MASH modulator.
// Build option NCSP_SEED_LFSR_EN: seed comes from an internal LFSR instead of i_cfg_seed.
module ncsp_ddsm_ctrl
  import ncsp_ddsm_pkg::*;
#(
  parameter int P_RST_CYCLES = 4,
  parameter int P_DATA_WIDTH = 8
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_enable,
  input  logic                      i_cfg_valid,
  output logic                      o_cfg_ready,
  input  logic                      i_cfg_mode,
  input  logic [3*P_DATA_WIDTH-1:0] i_cfg_level,
  input  logic [SEED_W-1:0]         i_cfg_seed,
  input  logic [SUM_SEL_W-1:0]      i_cfg_sum_sel,
  input  logic [COUT_SEL_W-1:0]     i_cfg_cout_sel,
  output logic                      o_rst_n,
  output logic                      o_rst_n_1d,
  output logic [P_DATA_WIDTH-1:0]   o_level1_data,
  output logic [P_DATA_WIDTH-1:0]   o_level2_data,
  output logic [P_DATA_WIDTH-1:0]   o_level3_data,
  output logic [SEED_W-1:0]         o_seed,
  output logic [SUM_SEL_W-1:0]      o_sum_sel,
  output logic [COUT_SEL_W-1:0]     o_cout_sel,
  output logic                      o_running,
  output state_e                    o_dbg_state
);

  localparam int              CNT_W    = (P_RST_CYCLES > 1) ? $clog2(P_RST_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(P_RST_CYCLES - 1);

  // Handshake: a config transfers on any clock edge where i_cfg_valid and
  // o_cfg_ready are both high; ready is low only while a restart is in flight.
  logic       w_accept;
  logic       w_full_acc;
  state_e     r_state;
  state_e     w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic       r_loaded;

  assign w_accept    = i_cfg_valid & o_cfg_ready;
  assign w_full_acc  = w_accept & ~i_cfg_mode;
  assign o_dbg_state = r_state;

  // Disable wins over every other transition; hops never move the state.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    if (!i_enable) begin
      w_state_nxt = ST_IDLE;
      w_cnt_nxt   = '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (r_loaded || w_full_acc) begin
            w_state_nxt = ST_RST;
            w_cnt_nxt   = '0;
          end
        end
        ST_RST: begin
          if (r_cnt == CNT_LAST) begin
            w_state_nxt = ST_REL;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
        ST_REL: begin
          w_state_nxt = ST_RUN;
        end
        ST_RUN: begin
          if (w_full_acc) begin
            w_state_nxt = ST_RST;
            w_cnt_nxt   = '0;
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  // Outputs are registered from the next state so they line up with r_state.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      o_rst_n     <= 1'b0;
      o_rst_n_1d  <= 1'b0;
      o_running   <= 1'b0;
      o_cfg_ready <= 1'b1;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      o_rst_n     <= (w_state_nxt == ST_REL) || (w_state_nxt == ST_RUN);
      o_rst_n_1d  <= (w_state_nxt == ST_RUN);
      o_running   <= (w_state_nxt == ST_RUN);
      o_cfg_ready <= (w_state_nxt == ST_IDLE) || (w_state_nxt == ST_RUN);
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_loaded      <= 1'b0;
      o_level1_data <= '0;
      o_level2_data <= '0;
      o_level3_data <= '0;
      o_sum_sel     <= '0;
      o_cout_sel    <= '0;
    end else begin
      if (w_accept) begin
        o_level1_data <= i_cfg_level[3*P_DATA_WIDTH-1:2*P_DATA_WIDTH];
        o_level2_data <= i_cfg_level[2*P_DATA_WIDTH-1:P_DATA_WIDTH];
        o_level3_data <= i_cfg_level[P_DATA_WIDTH-1:0];
      end
      if (w_full_acc) begin
        r_loaded   <= 1'b1;
        o_sum_sel  <= i_cfg_sum_sel;
        o_cout_sel <= i_cfg_cout_sel;
      end
    end
  end

`ifdef NCSP_SEED_LFSR_EN
  ncsp_seed_lfsr u_seed_lfsr (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_advance (w_full_acc),
    .o_value   (o_seed)
  );
`else
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_seed <= '0;
    end else if (w_full_acc) begin
      o_seed <= i_cfg_seed;
    end
  end
`endif

endmodule

// File: tb/tb_ncsp_ddsm_ctrl.sv
// Scoreboard bench for ncsp_ddsm_ctrl: a timeline model predicts every cycle's outputs.
// Also builds with NCSP_SEED_LFSR_EN defined.
module tb_ncsp_ddsm_ctrl;
  import ncsp_ddsm_pkg::*;

  localparam int P_RST = 4;
  localparam int DW    = 8;
  localparam int VW    = 3*DW + 33;

  logic            clk = 1'b0;
  logic            i_rst = 1'b1;
  logic            i_enable = 1'b0;
  logic            i_cfg_valid = 1'b0;
  logic            i_cfg_mode = 1'b0;
  logic [3*DW-1:0] i_cfg_level = '0;
  logic [11:0]     i_cfg_seed = '0;
  logic [7:0]      i_cfg_sum_sel = '0;
  logic [8:0]      i_cfg_cout_sel = '0;
  logic            o_cfg_ready, o_rst_n, o_rst_n_1d, o_running;
  logic [DW-1:0]   o_level1_data, o_level2_data, o_level3_data;
  logic [11:0]     o_seed;
  logic [7:0]      o_sum_sel;
  logic [8:0]      o_cout_sel;
  state_e          dbg_state;

  ncsp_ddsm_ctrl #(.P_RST_CYCLES(P_RST), .P_DATA_WIDTH(DW)) dut (
    .i_clk(clk), .i_rst(i_rst), .i_enable(i_enable),
    .i_cfg_valid(i_cfg_valid), .o_cfg_ready(o_cfg_ready), .i_cfg_mode(i_cfg_mode),
    .i_cfg_level(i_cfg_level), .i_cfg_seed(i_cfg_seed),
    .i_cfg_sum_sel(i_cfg_sum_sel), .i_cfg_cout_sel(i_cfg_cout_sel),
    .o_rst_n(o_rst_n), .o_rst_n_1d(o_rst_n_1d),
    .o_level1_data(o_level1_data), .o_level2_data(o_level2_data), .o_level3_data(o_level3_data),
    .o_seed(o_seed), .o_sum_sel(o_sum_sel), .o_cout_sel(o_cout_sel),
    .o_running(o_running), .o_dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cycle    = 0;
  logic [VW-1:0] exp_q[$];

  always @(posedge clk) cycle++;

  // ---------------- reference model ----------------
  // m_t counts cycles since a restart began: 0 = idle/held, 1..P = reset low,
  // P+1 = stage-1 still held, P+2 = running.
  int          m_t;
  bit          m_loaded;
  logic [DW-1:0] m_l1, m_l2, m_l3;
  logic [11:0] m_seed, m_lfsr;
  logic [7:0]  m_sum;
  logic [8:0]  m_cout;

  function automatic logic [11:0] poly_step(input logic [11:0] s);
    logic fb;
    fb = s[11] ^ s[5] ^ s[3] ^ s[0];
    return {s[10:0], fb};
  endfunction

  function automatic logic [VW-1:0] model_vec();
    logic rn, rn1, rdy;
    rn  = (m_t > P_RST);
    rn1 = (m_t > P_RST + 1);
    rdy = (m_t == 0) || (m_t > P_RST + 1);
    return {rn, rn1, rn1, rdy, m_l1, m_l2, m_l3, m_seed, m_sum, m_cout};
  endfunction

  function automatic logic [VW-1:0] dut_vec();
    return {o_rst_n, o_rst_n_1d, o_running, o_cfg_ready, o_level1_data, o_level2_data,
            o_level3_data, o_seed, o_sum_sel, o_cout_sel};
  endfunction

  task automatic model_reset();
    m_t = 0; m_loaded = 0;
    m_l1 = '0; m_l2 = '0; m_l3 = '0;
    m_sum = '0; m_cout = '0;
    m_lfsr = 12'hACE;
`ifdef NCSP_SEED_LFSR_EN
    m_seed = 12'hACE;
`else
    m_seed = '0;
`endif
  endtask

  // ---------------- driver tasks ----------------
  task automatic step(input bit en, input bit valid, input bit mode, input logic [3*DW-1:0] lvl,
                      input logic [11:0] seed, input logic [7:0] sum, input logic [8:0] cout);
    bit rdy, acc;
    @(negedge clk);
    i_rst = 1'b0; i_enable = en; i_cfg_valid = valid; i_cfg_mode = mode;
    i_cfg_level = lvl; i_cfg_seed = seed; i_cfg_sum_sel = sum; i_cfg_cout_sel = cout;
    rdy = (m_t == 0) || (m_t > P_RST + 1);
    acc = valid && rdy;
    if (acc) begin
      m_l1 = lvl[3*DW-1:2*DW]; m_l2 = lvl[2*DW-1:DW]; m_l3 = lvl[DW-1:0];
      if (!mode) begin
        m_loaded = 1; m_sum = sum; m_cout = cout;
`ifdef NCSP_SEED_LFSR_EN
        m_lfsr = poly_step(m_lfsr); m_seed = m_lfsr;
`else
        m_seed = seed;
`endif
      end
    end
    if (!en) m_t = 0;
    else if (m_t == 0) begin
      if (m_loaded) m_t = 1;
    end else if (m_t > P_RST + 1) begin
      if (acc && !mode) m_t = 1;
    end else m_t++;
    exp_q.push_back(model_vec());
  endtask

  task automatic wait_steps(input int n, input bit en);
    for (int i = 0; i < n; i++) step(en, 0, 0, '0, '0, '0, '0);
  endtask

  task automatic do_reset();
    logic [VW-1:0] got, want;
    @(negedge clk);
    model_reset();
    exp_q.push_back(model_vec());
    #1 i_rst = 1'b1;
    #1;
    got = dut_vec(); want = model_vec();
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL reset_async t=%0t got=%h exp=%h", $time, got, want);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(posedge clk) begin
    logic [VW-1:0] e, a;
    #2;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      a = dut_vec();
      n_checks++;
      if (a !== e) begin
        n_errors++;
        $display("FAIL outputs cycle=%0d got=%h exp=%h", cycle, a, e);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    model_reset();
    do_reset();
    wait_steps(3, 1);
    // First full config, then hops while running.
    step(1, 1, 0, 24'h402010, 12'h123, 8'hA5, 9'h1F3);
    wait_steps(P_RST + 3, 1);
    step(1, 1, 1, 24'h010101, 12'hFFF, 8'h00, 9'h000);
    step(1, 1, 1, 24'h020202, 12'hFFF, 8'h00, 9'h000);
    step(1, 1, 1, 24'h030303, 12'hFFF, 8'h00, 9'h000);
    wait_steps(2, 1);
    // Hop before any full config, then a full config while disabled.
    do_reset();
    step(1, 1, 1, 24'h0A0B0C, 12'h000, 8'h00, 9'h000);
    wait_steps(2, 1);
    step(0, 1, 0, 24'h112233, 12'h456, 8'h3C, 9'h0AA);
    wait_steps(3, 0);
    wait_steps(P_RST + 4, 1);
    // Disable with the reset counter at 2, then re-enable.
    step(1, 1, 0, 24'h445566, 12'h789, 8'h5A, 9'h155);
    wait_steps(2, 1);
    wait_steps(1, 0);
    wait_steps(P_RST + 4, 1);
    // Valid held through a restart.
    step(1, 1, 0, 24'h778899, 12'hABC, 8'h77, 9'h077);
    for (int i = 0; i < P_RST + 3; i++) step(1, 1, 1, 24'h777777, 12'h000, 8'h00, 9'h000);
    wait_steps(2, 1);
    // Asynchronous reset in the middle of a restart.
    step(1, 1, 0, 24'hCAFE01, 12'h321, 8'h12, 9'h034);
    wait_steps(2, 1);
    do_reset();
    wait_steps(2, 1);
    // Randomised traffic.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 199) == 0) do_reset();
      else step($urandom_range(0, 15) != 0, 1'($urandom_range(0, 1)), $urandom_range(0, 2) != 0,
                (3*DW)'($urandom), 12'($urandom), 8'($urandom), 9'($urandom));
    end
    @(posedge clk);
    #4;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL drain got=%0d exp=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/ncsp_ddsm_ctrl.md
# ncsp_ddsm_ctrl

Configuration and reset sequencer for the NCSP MASH delta-sigma modulator. It accepts frequency-word updates over a valid/ready handshake and drives the modulator's level data, seed, sum/carry selects and its two staggered active-low resets. Full reconfigurations restart the modulator cleanly. "Hop" updates change only the level data while the modulator keeps running. It sits between the register/control plane and the MASH instance.

## Interface
- P_RST_CYCLES, 4, cycles o_rst_n is held low per restart (legal ≥1)
- P_DATA_WIDTH, 8, width of each level word
- i_clk  in  1  sole clock
- i_rst  in  1  reset: one clock; reset is asynchronous and active-high
- i_enable  in  1  run enable; low forces modulator into reset
- i_cfg_valid  in  1  config request
- o_cfg_ready  out  1  config accept
- i_cfg_mode  in  1  0 = full restart, 1 = hop (level data only)
- i_cfg_level  in  3*P_DATA_WIDTH  {level1, level2, level3}
- i_cfg_seed  in  12  seed (ignored when LFSR seeding compiled in)
- i_cfg_sum_sel  in  8  sum select
- i_cfg_cout_sel  in  9  carry-out select
- o_rst_n  out  1  modulator reset for stages 2/3
- o_rst_n_1d  out  1  modulator reset for stage 1, released one cycle after o_rst_n
- o_level1_data / o_level2_data / o_level3_data  out  P_DATA_WIDTH each  level words
- o_seed  out  12;  o_sum_sel  out  8;  o_cout_sel  out  9
- o_running  out  1  state is RUN

## Operation
- Handshake: accept when i_cfg_valid & o_cfg_ready. o_cfg_ready = 1 in IDLE and RUN, 0 in RST and REL.
- States:
  - IDLE: both resets low.
  - RST: o_rst_n = 0; counter runs 0..P_RST_CYCLES-1.
  - REL: o_rst_n = 1, o_rst_n_1d = 0, one cycle.
  - RUN: both resets high.
- Full config accepted:
  - Captures level, seed, sum_sel and cout_sel; sets the internal `loaded` flag.
  - From RUN: go to RST.
  - From IDLE: go to RST if i_enable = 1, else stay in IDLE.
- Hop accepted:
  - Captures level only; seed and selects are unchanged.
  - No state change in any state, and no reset pulse.
- IDLE → RST when i_enable & loaded, including the case where i_enable rises later.
- RST → REL when the counter reaches P_RST_CYCLES-1. REL → RUN unconditionally.
- i_enable = 0 overrides all transitions:
  - Next state is IDLE from any state, and the counter clears.
  - A config accepted in that same cycle is still captured.
- `loaded` is cleared only by i_rst. A hop before the first full config updates level only; it does not set `loaded`.
- All outputs are registered. Config registers change only on accept.

## Timing
- Reset values:
  - State IDLE, counter 0, `loaded` 0.
  - o_rst_n = 0, o_rst_n_1d = 0, o_running = 0, o_cfg_ready = 1.
  - Levels, o_seed, o_sum_sel and o_cout_sel all 0.
- Accept at edge k:
  - Captured values are visible from cycle k+1.
  - Full restart: o_rst_n is low in cycles k+1 .. k+P_RST_CYCLES.
  - o_rst_n rises at k+P_RST_CYCLES+1.
  - o_rst_n_1d and o_running rise at k+P_RST_CYCLES+2.
- Hop in RUN: level outputs change at k+1; both resets stay high; o_cfg_ready stays 1, so back-to-back hops are accepted every cycle.
- i_enable falls at edge k: both resets are low and o_running = 0 from k+1.
- Asynchronous i_rst mid-sequence: immediate return to reset values.

## Configuration
- NCSP_SEED_LFSR_EN defined:
  - o_seed comes from a 12-bit Fibonacci LFSR, polynomial x^12+x^6+x^4+x+1, reset value 12'hACE.
  - The LFSR advances one step on each accepted full config; the new value appears on o_seed at k+1.
  - i_cfg_seed is ignored.
- NCSP_SEED_LFSR_EN undefined: o_seed captures i_cfg_seed on full config; no LFSR logic exists.

## Structure
- Package ncsp_ddsm_pkg holds:
  - The state enum (IDLE, RST, REL, RUN).
  - The LFSR width, tap mask and reset constant 12'hACE.
  - Seed and select widths.
- One sub-module, ncsp_seed_lfsr, with ports clock, reset, advance and value. It is instantiated only under NCSP_SEED_LFSR_EN.

## Test plan
- Full config after reset with P_RST_CYCLES = 4, i_enable = 1, level {8'h40, 8'h20, 8'h10}, seed 12'h123:
  - Accept at k.
  - o_rst_n low k+1..k+4, high k+5; o_rst_n_1d high k+6.
  - Levels are 40/20/10 from k+1; o_seed = 12'h123.
- Hop in RUN, three consecutive cycles with levels 8'h01, 8'h02, 8'h03 for all three words:
  - Outputs follow one cycle later.
  - Resets stay high; sum_sel and seed are unchanged.
- Full config with i_enable = 0:
  - Stays in IDLE with resets low.
  - Raising i_enable starts RST the next cycle, and o_rst_n_1d rises 4+2 cycles after that.
- i_enable drops during RST, counter at 2:
  - Both resets low and IDLE next cycle.
  - Re-enable restarts a full 4-cycle RST.
- valid held high during RST/REL: o_cfg_ready = 0 and nothing is captured until RUN, then it is accepted in the first RUN cycle.
- With NCSP_SEED_LFSR_EN: two full configs give o_seed = 12'hACE stepped once, then twice, per the polynomial, regardless of i_cfg_seed.
